// File: rtl/memory_mapper_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : memory_mapper_pkg
//  Purpose  : Shared types for the multi-context memory mapper: page-table
//             entry layout, control-register indices and the context-switch
//             FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package memory_mapper_pkg;

    // Frame width the entry struct is built for; the top checks its own
    // FRAME_BITS parameter against this at elaboration.
    localparam int MM_FRAME_BITS = 12;

    // Page-table entry, laid out exactly as on cfg_wdata/cfg_rdata:
    // [F+1]=valid, [F]=write-protect, [F-1:0]=frame.
    typedef struct packed {
        logic                     valid;
        logic                     wp;
        logic [MM_FRAME_BITS-1:0] frame;
    } mm_entry_t;

    // Control-register indices (low two bits of cfg_addr with MSB set)
    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_CTX   = 2'd1;
    localparam logic [1:0] REG_FSTAT = 2'd2;
    localparam logic [1:0] REG_FINFO = 2'd3;

    // Context-switch FSM
    typedef enum logic [0:0] {
        SW_IDLE  = 1'b0,
        SW_ARMED = 1'b1
    } sw_state_e;

endpackage : memory_mapper_pkg
`default_nettype wire

// File: rtl/mm_ctx_switch.sv
`default_nettype none
// ============================================================================
//  Module   : mm_ctx_switch
//  Purpose  : Deferred task-switch controller. A CTX write arms the switch;
//             the active context changes only after SWITCH_DELAY opcode-fetch
//             strobes, so the switch lands on an instruction boundary.
//  Ports    : clk, rst_n         clock, async active-low reset
//             ctx_wr_i           CTX register write strobe
//             ctx_wdata_i        requested next context
//             cpu_sync_i         opcode-fetch strobe
//             active_o           context used for translation
//             pending_o          a switch is armed but not yet committed
//  Revision : 1.0  initial release
// ============================================================================
module mm_ctx_switch
    import memory_mapper_pkg::*;
#(
    parameter int CTX_BITS     = 2,
    parameter int SWITCH_DELAY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ctx_wr_i,
    input  logic [CTX_BITS-1:0] ctx_wdata_i,
    input  logic                cpu_sync_i,
    output logic [CTX_BITS-1:0] active_o,
    output logic                pending_o
);

    localparam int CNT_W = (SWITCH_DELAY < 2) ? 1 : $clog2(SWITCH_DELAY + 1);
    localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(SWITCH_DELAY);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    sw_state_e           state_q, state_d;
    logic [CTX_BITS-1:0] next_q,  next_d;
    logic [CTX_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SW_IDLE;
            next_q   <= '0;
            active_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            next_q   <= next_d;
            active_q <= active_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        next_d   = next_q;
        active_d = active_q;
        count_d  = count_q;

        // A CTX write always wins: it (re)loads the target and the countdown,
        // even while armed and even if a sync arrives in the same cycle.
        if (ctx_wr_i) begin
            next_d = ctx_wdata_i;
            if (SWITCH_DELAY == 0) begin
                active_d = ctx_wdata_i;
                state_d  = SW_IDLE;
            end else begin
                count_d = C_LOAD;
                state_d = SW_ARMED;
            end
        end else begin
            case (state_q)
                SW_ARMED: begin
                    if (cpu_sync_i) begin
                        if (count_q == C_ONE) begin
                            active_d = next_q;
                            count_d  = '0;
                            state_d  = SW_IDLE;
                        end else begin
                            count_d = count_q - C_ONE;
                        end
                    end
                end
                default: begin
                    state_d = SW_IDLE;
                end
            endcase
        end
    end

    assign active_o  = active_q;
    assign pending_o = (state_q == SW_ARMED);

endmodule : mm_ctx_switch
`default_nettype wire

// File: rtl/memory_mapper_ctx.sv
`default_nettype none
// ============================================================================
//  Module   : memory_mapper_ctx
//  Purpose  : Multi-context page mapper. Translates CPU page index ma through
//             the page table of the active context to a physical frame, with
//             valid/write-protect checking, sticky fault capture + IRQ and a
//             context switch deferred to an opcode fetch.
//  Ports    : clk, rst_n                 clock, async active-low reset
//             cfg_cs/cfg_rw/cfg_addr/    configuration window (entries and
//             cfg_wdata                  control registers)
//             cfg_rdata/cfg_rvalid       registered read return, 1-cycle lat.
//             cpu_access/cpu_rw/cpu_sync CPU bus qualifiers
//             ma -> mo                   page index in, frame out
//             mo_fault                   current access faults (comb)
//             irq                        fault interrupt (level)
//  Revision : 1.0  initial release
// ============================================================================
module memory_mapper_ctx
    import memory_mapper_pkg::*;
#(
    parameter int PAGE_BITS    = 4,
    parameter int FRAME_BITS   = 12,
    parameter int CTX_BITS     = 2,
    parameter int SWITCH_DELAY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_cs,
    input  logic                          cfg_rw,
    input  logic [CTX_BITS+PAGE_BITS:0]   cfg_addr,
    input  logic [FRAME_BITS+1:0]         cfg_wdata,
    output logic [FRAME_BITS+1:0]         cfg_rdata,
    output logic                          cfg_rvalid,
    input  logic                          cpu_access,
    input  logic                          cpu_rw,
    input  logic                          cpu_sync,
    input  logic [PAGE_BITS-1:0]          ma,
    output logic [FRAME_BITS-1:0]         mo,
    output logic                          mo_fault,
    output logic                          irq
);

    localparam int IDX_BITS  = CTX_BITS + PAGE_BITS;
    localparam int ADDR_BITS = IDX_BITS + 1;
    localparam int DATA_BITS = FRAME_BITS + 2;
    localparam int INFO_BITS = 1 + CTX_BITS + PAGE_BITS;
    localparam int NUM_ENTRY = 1 << IDX_BITS;

    if (FRAME_BITS != MM_FRAME_BITS || FRAME_BITS < PAGE_BITS) begin : g_param_check
        $error("memory_mapper_ctx: unsupported FRAME_BITS/PAGE_BITS combination");
    end

    // ------------------------------------------------------------------
    // Config-window decode
    // ------------------------------------------------------------------
    logic                w_wr, w_rd, w_is_reg;
    logic [1:0]          w_reg_idx;
    logic [IDX_BITS-1:0] w_idx;

    assign w_wr      = cfg_cs & ~cfg_rw;
    assign w_rd      = cfg_cs &  cfg_rw;
    assign w_is_reg  = cfg_addr[ADDR_BITS-1];
    assign w_reg_idx = cfg_addr[1:0];
    assign w_idx     = cfg_addr[IDX_BITS-1:0];

    logic w_wr_ctrl, w_wr_ctx, w_wr_fstat;
    assign w_wr_ctrl  = w_wr & w_is_reg & (w_reg_idx == REG_CTRL);
    assign w_wr_ctx   = w_wr & w_is_reg & (w_reg_idx == REG_CTX);
    assign w_wr_fstat = w_wr & w_is_reg & (w_reg_idx == REG_FSTAT);

    // ------------------------------------------------------------------
    // Page table: plain RAM, deliberately not reset
    // ------------------------------------------------------------------
    mm_entry_t table_q [NUM_ENTRY];

    always_ff @(posedge clk) begin
        if (w_wr && !w_is_reg) begin
            table_q[w_idx] <= mm_entry_t'(cfg_wdata);
        end
    end

    // ------------------------------------------------------------------
    // Context switch
    // ------------------------------------------------------------------
    logic [CTX_BITS-1:0] w_active;
    logic                w_pending;

    mm_ctx_switch #(
        .CTX_BITS     (CTX_BITS),
        .SWITCH_DELAY (SWITCH_DELAY)
    ) u_ctx_switch (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctx_wr_i    (w_wr_ctx),
        .ctx_wdata_i (cfg_wdata[CTX_BITS-1:0]),
        .cpu_sync_i  (cpu_sync),
        .active_o    (w_active),
        .pending_o   (w_pending)
    );

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic                 enable_q, irq_en_q;
    logic                 fault_q, fault_d;
    logic                 ovr_q, ovr_d;
    logic [INFO_BITS-1:0] info_q, info_d;

    // ------------------------------------------------------------------
    // Translation
    // ------------------------------------------------------------------
    mm_entry_t       w_entry;
    logic [FRAME_BITS-1:0] w_pass;

    assign w_entry = table_q[{w_active, ma}];

    always_comb begin
        w_pass                 = '0;
        w_pass[PAGE_BITS-1:0]  = ma;
    end

    assign mo       = enable_q ? w_entry.frame : w_pass;
    assign mo_fault = enable_q & cpu_access & (~w_entry.valid | (w_entry.wp & ~cpu_rw));
    assign irq      = fault_q & irq_en_q;

    // ------------------------------------------------------------------
    // Fault capture. A clear write is applied first, so a fault arriving in
    // the same cycle is treated as the first fault of a fresh episode.
    // Info uses the registered active context, i.e. the pre-switch one.
    // ------------------------------------------------------------------
    always_comb begin
        fault_d = fault_q & ~w_wr_fstat;
        ovr_d   = ovr_q   & ~w_wr_fstat;
        info_d  = info_q;
        if (mo_fault) begin
            if (!fault_d) begin
                fault_d = 1'b1;
                info_d  = {cpu_rw, w_active, ma};
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
            fault_q  <= 1'b0;
            ovr_q    <= 1'b0;
            info_q   <= '0;
        end else begin
            if (w_wr_ctrl) begin
                enable_q <= cfg_wdata[0];
                irq_en_q <= cfg_wdata[1];
            end
            fault_q <= fault_d;
            ovr_q   <= ovr_d;
            info_q  <= info_d;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] w_rd_mux;
    logic [DATA_BITS-1:0] rdata_q;
    logic                 rvalid_q;

    always_comb begin
        w_rd_mux = '0;
        if (!w_is_reg) begin
            w_rd_mux = table_q[w_idx];
        end else begin
            case (w_reg_idx)
                REG_CTRL: begin
                    w_rd_mux[0] = enable_q;
                    w_rd_mux[1] = irq_en_q;
                end
                REG_CTX: begin
                    w_rd_mux[CTX_BITS-1:0] = w_active;
                    w_rd_mux[CTX_BITS]     = w_pending;
                end
                REG_FSTAT: begin
                    w_rd_mux[0] = fault_q;
                    w_rd_mux[1] = ovr_q;
                end
                default: begin
                    w_rd_mux[INFO_BITS-1:0] = info_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= w_rd;
            if (w_rd) begin
                rdata_q <= w_rd_mux;
            end
        end
    end

    assign cfg_rdata  = rdata_q;
    assign cfg_rvalid = rvalid_q;

endmodule : memory_mapper_ctx
`default_nettype wire
